// File: rtl/rpn_stack.sv
// rpn_stack: operand stack for the RPN calculator datapath.
// Holds up to DEPTH operands and exposes top/next to the BCD ALU. It supports
// push/pop/dup/swap, a pop-two/push-one ALU writeback (BINOP) and clear, with
// full/empty flags and sticky underflow/overflow error bits.
module rpn_stack #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_op_valid,
   input  logic [2:0]            i_op,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_err_clr,
   output logic [DATA_WIDTH-1:0] o_top,
   output logic [DATA_WIDTH-1:0] o_next,
   output logic [CNT_WIDTH-1:0]  o_depth,
   output logic                  o_empty,
   output logic                  o_full,
   output logic [1:0]            o_err,
   output logic                  o_done
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   localparam logic [2:0] OP_PUSH  = 3'd1;
   localparam logic [2:0] OP_POP   = 3'd2;
   localparam logic [2:0] OP_DUP   = 3'd3;
   localparam logic [2:0] OP_SWAP  = 3'd4;
   localparam logic [2:0] OP_BINOP = 3'd5;
   localparam logic [2:0] OP_CLEAR = 3'd6;

   // Registered state
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [CNT_WIDTH-1:0]  r_depth;
   logic [1:0]            r_err;
   logic                  r_done;

   // Derived stack addressing and status
   logic [IDX_W-1:0]      w_idx_wr;
   logic [IDX_W-1:0]      w_idx_top;
   logic [IDX_W-1:0]      w_idx_nxt;
   logic [DATA_WIDTH-1:0] w_top_val;
   logic [DATA_WIDTH-1:0] w_nxt_val;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_lt2;

   // Next-state controls
   logic                  w_wr_en_a;
   logic [IDX_W-1:0]      w_wr_idx_a;
   logic [DATA_WIDTH-1:0] w_wr_data_a;
   logic                  w_wr_en_b;
   logic [IDX_W-1:0]      w_wr_idx_b;
   logic [DATA_WIDTH-1:0] w_wr_data_b;
   logic [CNT_WIDTH-1:0]  w_depth_nxt;
   logic                  w_ok;
   logic                  w_uf;
   logic                  w_of;
   logic [1:0]            w_err_nxt;

   // Entry addresses relative to the current depth; only used when the guarding condition holds
   always_comb begin
      w_idx_wr  = IDX_W'(r_depth);
      w_idx_top = IDX_W'(r_depth - CNT_WIDTH'(1));
      w_idx_nxt = IDX_W'(r_depth - CNT_WIDTH'(2));
      w_top_val = r_mem[w_idx_top];
      w_nxt_val = r_mem[w_idx_nxt];
      w_empty   = (r_depth == '0);
      w_full    = (r_depth == CNT_WIDTH'(DEPTH));
      w_lt2     = (r_depth < CNT_WIDTH'(2));
   end

   // Decode the command into up to two entry writes, the new depth and error/done events
   always_comb begin
      w_wr_en_a   = 1'b0;
      w_wr_idx_a  = w_idx_wr;
      w_wr_data_a = i_data;
      w_wr_en_b   = 1'b0;
      w_wr_idx_b  = w_idx_nxt;
      w_wr_data_b = w_top_val;
      w_depth_nxt = r_depth;
      w_ok        = 1'b0;
      w_uf        = 1'b0;
      w_of        = 1'b0;
      if (i_op_valid) begin
         case (i_op)
            OP_PUSH: begin
               if (w_full) begin
                  w_of = 1'b1;
               end else begin
                  w_wr_en_a   = 1'b1;
                  w_depth_nxt = r_depth + CNT_WIDTH'(1);
                  w_ok        = 1'b1;
               end
            end
            OP_POP: begin
               if (w_empty) begin
                  w_uf = 1'b1;
               end else begin
                  w_depth_nxt = r_depth - CNT_WIDTH'(1);
                  w_ok        = 1'b1;
               end
            end
            OP_DUP: begin
               if (w_empty) begin
                  w_uf = 1'b1;
               end else if (w_full) begin
                  w_of = 1'b1;
               end else begin
                  w_wr_en_a   = 1'b1;
                  w_wr_data_a = w_top_val;
                  w_depth_nxt = r_depth + CNT_WIDTH'(1);
                  w_ok        = 1'b1;
               end
            end
            OP_SWAP: begin
               if (w_lt2) begin
                  w_uf = 1'b1;
               end else begin
                  w_wr_en_a   = 1'b1;
                  w_wr_idx_a  = w_idx_top;
                  w_wr_data_a = w_nxt_val;
                  w_wr_en_b   = 1'b1;
                  w_wr_idx_b  = w_idx_nxt;
                  w_wr_data_b = w_top_val;
                  w_ok        = 1'b1;
               end
            end
            OP_BINOP: begin
               // ALU result replaces the two operands it consumed
               if (w_lt2) begin
                  w_uf = 1'b1;
               end else begin
                  w_wr_en_a   = 1'b1;
                  w_wr_idx_a  = w_idx_nxt;
                  w_depth_nxt = r_depth - CNT_WIDTH'(1);
                  w_ok        = 1'b1;
               end
            end
            OP_CLEAR: begin
               w_depth_nxt = '0;
               w_ok        = 1'b1;
            end
            default: begin
               w_ok = 1'b0;
            end
         endcase
      end
   end

   // Sticky error bits; a clear keeps only the error raised in the same cycle
   always_comb begin
      w_err_nxt = r_err | {w_of, w_uf};
      if (i_err_clr) begin
         w_err_nxt = {w_of, w_uf};
      end
   end

   // Stack storage, depth counter, error and done registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
         r_depth <= '0;
         r_err   <= '0;
         r_done  <= 1'b0;
      end else begin
         if (w_wr_en_a) begin
            r_mem[w_wr_idx_a] <= w_wr_data_a;
         end
         if (w_wr_en_b) begin
            r_mem[w_wr_idx_b] <= w_wr_data_b;
         end
         r_depth <= w_depth_nxt;
         r_err   <= w_err_nxt;
         r_done  <= w_ok;
      end
   end

   // Views of the registered state; empty-masked so unused entries never leak out
   always_comb begin
      o_top   = w_empty ? '0 : w_top_val;
      o_next  = w_lt2   ? '0 : w_nxt_val;
      o_depth = r_depth;
      o_empty = w_empty;
      o_full  = w_full;
      o_err   = r_err;
      o_done  = r_done;
   end

endmodule

// File: tb/tb_rpn_stack.sv
// Directed testbench for rpn_stack (DATA_WIDTH=16, DEPTH=8).
module tb_rpn_stack;

   localparam int unsigned DW = 16;
   localparam int unsigned CW = 4;

   logic          clk;
   logic          rst_n;
   logic          op_valid;
   logic [2:0]    op;
   logic [DW-1:0] data;
   logic          err_clr;
   logic [DW-1:0] top;
   logic [DW-1:0] nxt;
   logic [CW-1:0] depth;
   logic          empty;
   logic          full;
   logic [1:0]    err;
   logic          done;

   int checks   = 0;
   int failures = 0;

   localparam logic [2:0] NOP   = 3'd0;
   localparam logic [2:0] PUSH  = 3'd1;
   localparam logic [2:0] POP   = 3'd2;
   localparam logic [2:0] DUP   = 3'd3;
   localparam logic [2:0] SWAP  = 3'd4;
   localparam logic [2:0] BINOP = 3'd5;
   localparam logic [2:0] CLEAR = 3'd6;
   localparam logic [2:0] NOP7  = 3'd7;

   rpn_stack #(.DATA_WIDTH(DW), .DEPTH(8)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_op_valid (op_valid),
      .i_op       (op),
      .i_data     (data),
      .i_err_clr  (err_clr),
      .o_top      (top),
      .o_next     (nxt),
      .o_depth    (depth),
      .o_empty    (empty),
      .o_full     (full),
      .o_err      (err),
      .o_done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one command for one rising edge, then observe 1 time unit after that edge
   task automatic issue(input logic [2:0] o, input logic [DW-1:0] d, input logic v, input logic c);
      op_valid = v;
      op       = o;
      data     = d;
      err_clr  = c;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      op       = NOP;
      data     = '0;
      err_clr  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; op_valid = 1'b0; op = NOP; data = '0; err_clr = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (top !== 16'h0)   begin failures++; $display("FAIL reset_top got=%h exp=%h", top, 16'h0); end
      checks++; if (nxt !== 16'h0)   begin failures++; $display("FAIL reset_next got=%h exp=%h", nxt, 16'h0); end
      checks++; if (depth !== 4'd0)  begin failures++; $display("FAIL reset_depth got=%0d exp=0", depth); end
      checks++; if (empty !== 1'b1)  begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0)   begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (err !== 2'b00)   begin failures++; $display("FAIL reset_err got=%b exp=00", err); end
      checks++; if (done !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
   endtask

   task automatic test_push();
      issue(PUSH, 16'h0012, 1'b1, 1'b0);
      checks++; if (done !== 1'b1)     begin failures++; $display("FAIL push1_done got=%b exp=1", done); end
      checks++; if (top !== 16'h0012)  begin failures++; $display("FAIL push1_top got=%h exp=0012", top); end
      checks++; if (nxt !== 16'h0)     begin failures++; $display("FAIL push1_next got=%h exp=0000", nxt); end
      issue(PUSH, 16'h0034, 1'b1, 1'b0);
      checks++; if (done !== 1'b1)     begin failures++; $display("FAIL push2_done got=%b exp=1", done); end
      checks++; if (depth !== 4'd2)    begin failures++; $display("FAIL push2_depth got=%0d exp=2", depth); end
      checks++; if (top !== 16'h0034)  begin failures++; $display("FAIL push2_top got=%h exp=0034", top); end
      checks++; if (nxt !== 16'h0012)  begin failures++; $display("FAIL push2_next got=%h exp=0012", nxt); end
      checks++; if (err !== 2'b00)     begin failures++; $display("FAIL push2_err got=%b exp=00", err); end
      issue(NOP, 16'h0, 1'b0, 1'b0);
      checks++; if (done !== 1'b0)     begin failures++; $display("FAIL idle_done got=%b exp=0", done); end
   endtask

   task automatic test_swap_binop();
      issue(SWAP, 16'h0, 1'b1, 1'b0);
      checks++; if (top !== 16'h0012)  begin failures++; $display("FAIL swap_top got=%h exp=0012", top); end
      checks++; if (nxt !== 16'h0034)  begin failures++; $display("FAIL swap_next got=%h exp=0034", nxt); end
      checks++; if (depth !== 4'd2)    begin failures++; $display("FAIL swap_depth got=%0d exp=2", depth); end
      checks++; if (done !== 1'b1)     begin failures++; $display("FAIL swap_done got=%b exp=1", done); end
      issue(BINOP, 16'h0046, 1'b1, 1'b0);
      checks++; if (depth !== 4'd1)    begin failures++; $display("FAIL binop_depth got=%0d exp=1", depth); end
      checks++; if (top !== 16'h0046)  begin failures++; $display("FAIL binop_top got=%h exp=0046", top); end
      checks++; if (nxt !== 16'h0)     begin failures++; $display("FAIL binop_next got=%h exp=0000", nxt); end
      checks++; if (done !== 1'b1)     begin failures++; $display("FAIL binop_done got=%b exp=1", done); end
   endtask

   task automatic test_dup_clear();
      issue(DUP, 16'h0, 1'b1, 1'b0);
      checks++; if (depth !== 4'd2)    begin failures++; $display("FAIL dup_depth got=%0d exp=2", depth); end
      checks++; if (top !== 16'h0046)  begin failures++; $display("FAIL dup_top got=%h exp=0046", top); end
      checks++; if (nxt !== 16'h0046)  begin failures++; $display("FAIL dup_next got=%h exp=0046", nxt); end
      issue(CLEAR, 16'h0, 1'b1, 1'b0);
      checks++; if (depth !== 4'd0)    begin failures++; $display("FAIL clear_depth got=%0d exp=0", depth); end
      checks++; if (empty !== 1'b1)    begin failures++; $display("FAIL clear_empty got=%b exp=1", empty); end
      checks++; if (top !== 16'h0)     begin failures++; $display("FAIL clear_top got=%h exp=0000", top); end
      checks++; if (done !== 1'b1)     begin failures++; $display("FAIL clear_done got=%b exp=1", done); end
   endtask

   task automatic test_underflow();
      issue(POP, 16'h0, 1'b1, 1'b0);
      checks++; if (err !== 2'b01)     begin failures++; $display("FAIL pop_empty_err got=%b exp=01", err); end
      checks++; if (done !== 1'b0)     begin failures++; $display("FAIL pop_empty_done got=%b exp=0", done); end
      checks++; if (depth !== 4'd0)    begin failures++; $display("FAIL pop_empty_depth got=%0d exp=0", depth); end
      issue(SWAP, 16'h0, 1'b1, 1'b0);
      checks++; if (err !== 2'b01)     begin failures++; $display("FAIL swap_empty_err got=%b exp=01", err); end
      checks++; if (done !== 1'b0)     begin failures++; $display("FAIL swap_empty_done got=%b exp=0", done); end
      checks++; if (depth !== 4'd0)    begin failures++; $display("FAIL swap_empty_depth got=%0d exp=0", depth); end
      issue(NOP, 16'h0, 1'b0, 1'b1);
      checks++; if (err !== 2'b00)     begin failures++; $display("FAIL err_clr got=%b exp=00", err); end
      // One entry: BINOP needs two operands
      issue(PUSH, 16'h0099, 1'b1, 1'b0);
      issue(BINOP, 16'h1111, 1'b1, 1'b0);
      checks++; if (err !== 2'b01)     begin failures++; $display("FAIL binop_d1_err got=%b exp=01", err); end
      checks++; if (top !== 16'h0099)  begin failures++; $display("FAIL binop_d1_top got=%h exp=0099", top); end
      checks++; if (depth !== 4'd1)    begin failures++; $display("FAIL binop_d1_depth got=%0d exp=1", depth); end
      issue(POP, 16'h0, 1'b1, 1'b1);
      checks++; if (empty !== 1'b1)    begin failures++; $display("FAIL pop_to_empty got=%b exp=1", empty); end
      checks++; if (err !== 2'b00)     begin failures++; $display("FAIL clr_no_new_err got=%b exp=00", err); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 8; i++) begin
         issue(PUSH, DW'(i), 1'b1, 1'b0);
         if (i == 7) begin
            checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_at7 got=%b exp=0", full); end
         end
      end
      checks++; if (full !== 1'b1)     begin failures++; $display("FAIL full_at8 got=%b exp=1", full); end
      checks++; if (top !== 16'h0008)  begin failures++; $display("FAIL full_top got=%h exp=0008", top); end
      checks++; if (nxt !== 16'h0007)  begin failures++; $display("FAIL full_next got=%h exp=0007", nxt); end
      checks++; if (depth !== 4'd8)    begin failures++; $display("FAIL full_depth got=%0d exp=8", depth); end
      issue(PUSH, 16'h0009, 1'b1, 1'b0);
      checks++; if (err !== 2'b10)     begin failures++; $display("FAIL push9_err got=%b exp=10", err); end
      checks++; if (top !== 16'h0008)  begin failures++; $display("FAIL push9_top got=%h exp=0008", top); end
      checks++; if (depth !== 4'd8)    begin failures++; $display("FAIL push9_depth got=%0d exp=8", depth); end
      checks++; if (done !== 1'b0)     begin failures++; $display("FAIL push9_done got=%b exp=0", done); end
      issue(DUP, 16'h0, 1'b1, 1'b0);
      checks++; if (err !== 2'b10)     begin failures++; $display("FAIL dup_full_err got=%b exp=10", err); end
      checks++; if (depth !== 4'd8)    begin failures++; $display("FAIL dup_full_depth got=%0d exp=8", depth); end
      // Errors do not block later ops
      issue(POP, 16'h0, 1'b1, 1'b0);
      checks++; if (depth !== 4'd7)    begin failures++; $display("FAIL pop_after_err_depth got=%0d exp=7", depth); end
      checks++; if (top !== 16'h0007)  begin failures++; $display("FAIL pop_after_err_top got=%h exp=0007", top); end
      checks++; if (done !== 1'b1)     begin failures++; $display("FAIL pop_after_err_done got=%b exp=1", done); end
      checks++; if (err !== 2'b10)     begin failures++; $display("FAIL err_sticky got=%b exp=10", err); end
   endtask

   task automatic test_err_collide();
      // Clear together with a new underflow: underflow kept, overflow dropped
      issue(CLEAR, 16'h0, 1'b1, 1'b0);
      issue(POP, 16'h0, 1'b1, 1'b1);
      checks++; if (err !== 2'b01)     begin failures++; $display("FAIL clr_collide_err got=%b exp=01", err); end
      checks++; if (done !== 1'b0)     begin failures++; $display("FAIL clr_collide_done got=%b exp=0", done); end
   endtask

   task automatic test_nop();
      issue(PUSH, 16'h00AB, 1'b1, 1'b0);
      issue(NOP, 16'h1234, 1'b1, 1'b0);
      checks++; if (done !== 1'b0)     begin failures++; $display("FAIL nop0_done got=%b exp=0", done); end
      checks++; if (depth !== 4'd1)    begin failures++; $display("FAIL nop0_depth got=%0d exp=1", depth); end
      issue(NOP7, 16'h1234, 1'b1, 1'b0);
      checks++; if (done !== 1'b0)     begin failures++; $display("FAIL nop7_done got=%b exp=0", done); end
      checks++; if (top !== 16'h00AB)  begin failures++; $display("FAIL nop7_top got=%h exp=00ab", top); end
      issue(PUSH, 16'h5555, 1'b0, 1'b0);
      checks++; if (depth !== 4'd1)    begin failures++; $display("FAIL novalid_depth got=%0d exp=1", depth); end
      checks++; if (done !== 1'b0)     begin failures++; $display("FAIL novalid_done got=%b exp=0", done); end
      checks++; if (err !== 2'b01)     begin failures++; $display("FAIL nop_err_kept got=%b exp=01", err); end
   endtask

   task automatic test_back_to_back();
      // Stack holds 00AB; consecutive ops on consecutive edges
      issue(PUSH, 16'h0005, 1'b1, 1'b0);
      issue(PUSH, 16'h0006, 1'b1, 1'b0);
      checks++; if (nxt !== 16'h0005)  begin failures++; $display("FAIL b2b_next got=%h exp=0005", nxt); end
      issue(BINOP, 16'h0011, 1'b1, 1'b0);
      checks++; if (top !== 16'h0011)  begin failures++; $display("FAIL b2b_binop_top got=%h exp=0011", top); end
      checks++; if (nxt !== 16'h00AB)  begin failures++; $display("FAIL b2b_binop_next got=%h exp=00ab", nxt); end
      issue(SWAP, 16'h0, 1'b1, 1'b0);
      checks++; if (top !== 16'h00AB)  begin failures++; $display("FAIL b2b_swap_top got=%h exp=00ab", top); end
      checks++; if (nxt !== 16'h0011)  begin failures++; $display("FAIL b2b_swap_next got=%h exp=0011", nxt); end
      checks++; if (done !== 1'b1)     begin failures++; $display("FAIL b2b_done got=%b exp=1", done); end
   endtask

   task automatic test_async_reset();
      issue(CLEAR, 16'h0, 1'b1, 1'b0);
      issue(POP, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         issue(PUSH, DW'(16'h0020 + i), 1'b1, 1'b0);
      end
      checks++; if (depth !== 4'd5)    begin failures++; $display("FAIL pre_rst_depth got=%0d exp=5", depth); end
      checks++; if (err !== 2'b01)     begin failures++; $display("FAIL pre_rst_err got=%b exp=01", err); end
      op_valid = 1'b1; op = PUSH; data = 16'h7777;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (depth !== 4'd0)    begin failures++; $display("FAIL arst_depth got=%0d exp=0", depth); end
      checks++; if (empty !== 1'b1)    begin failures++; $display("FAIL arst_empty got=%b exp=1", empty); end
      checks++; if (err !== 2'b00)     begin failures++; $display("FAIL arst_err got=%b exp=00", err); end
      checks++; if (top !== 16'h0)     begin failures++; $display("FAIL arst_top got=%h exp=0000", top); end
      @(posedge clk); #1;
      checks++; if (depth !== 4'd0)    begin failures++; $display("FAIL arst_hold_depth got=%0d exp=0", depth); end
      op_valid = 1'b0; op = NOP; data = '0;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (done !== 1'b0)     begin failures++; $display("FAIL post_rst_done got=%b exp=0", done); end
   endtask

   initial begin
      test_reset();
      test_push();
      test_swap_binop();
      test_dup_clear();
      test_underflow();
      test_overflow();
      test_err_collide();
      test_nop();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
